// File: rtl/hunt_the_bit_arcade.sv
// Hunt-the-bit game core: a lit bit walks the LED bank, the player presses the matching button.
// Optional HUNT_THE_BIT_LFSR_EN: after a hit flash, pos jumps to a pseudo-random LED.
module hunt_the_bit_arcade #(
  parameter int unsigned Width       = 16,
  parameter int unsigned MaxPeriod   = 25_000_000,
  parameter int unsigned MinPeriod   = 2_500_000,
  parameter int unsigned PeriodStep  = 2_500_000,
  parameter int unsigned LevelUpHits = 8,
  parameter int unsigned MaxLevel    = 15,
  parameter int unsigned Lives       = 3,
  parameter int unsigned FlashCycles = 5_000_000,
  parameter int unsigned PointsWidth = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [Width-1:0]                button,
  input  logic                            start,
  input  logic                            dir,
  output logic [Width-1:0]                led,
  output logic [PointsWidth-1:0]          points,
  output logic [$clog2(MaxLevel+1)-1:0]   level,
  output logic [$clog2(Lives+1)-1:0]      lives,
  output logic                            game_over
);

  localparam int unsigned PosW   = $clog2(Width);
  localparam int unsigned CntMax = (MaxPeriod > FlashCycles) ? MaxPeriod : FlashCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned PerW   = $clog2(MaxPeriod + 1);
  localparam int unsigned HitW   = $clog2(LevelUpHits + 1);
  localparam int unsigned LevelW = $clog2(MaxLevel + 1);
  localparam int unsigned LivesW = $clog2(Lives + 1);

  typedef enum logic [1:0] {StIdle, StPlay, StFlash, StOver} state_e;

  state_e                 state_q, state_d;
  logic [PosW-1:0]        pos_q, pos_d, flash_pos;
  logic [CntW-1:0]        tick_q, tick_d;
  logic [PerW-1:0]        period_q, period_d;
  logic [HitW-1:0]        hits_q, hits_d;
  logic [PointsWidth-1:0] points_q, points_d;
  logic [PointsWidth:0]   sum;
  logic [LevelW-1:0]      level_q, level_d;
  logic [LivesW-1:0]      lives_q, lives_d;
  logic                   blink_q, blink_d;
  logic [Width-1:0]       button_q, btn_edge, onehot;
  logic                   start_q, start_edge;

  function automatic logic [PosW-1:0] step_pos(input logic [PosW-1:0] p, input logic d);
    if (d) return (p == '0) ? PosW'(Width - 1) : p - 1'b1;
    else   return (p == PosW'(Width - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef HUNT_THE_BIT_LFSR_EN
  logic [15:0]     lfsr_q;
  logic [PosW-1:0] rnd;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Fold the random index into range; never land on the LED that was just hit.
  always_comb begin
    rnd = lfsr_q[PosW-1:0];
    if (32'(rnd) >= Width) rnd = rnd - PosW'(Width);
    flash_pos = (rnd == pos_q) ? step_pos(pos_q, dir) : rnd;
  end
`else
  assign flash_pos = step_pos(pos_q, dir);
`endif

  assign btn_edge   = button & ~button_q;
  assign start_edge = start & ~start_q;
  assign onehot     = Width'(1) << pos_q;
  assign sum        = {1'b0, points_q} + (PointsWidth+1)'(level_q) + (PointsWidth+1)'(1);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    tick_d   = tick_q;
    period_d = period_q;
    hits_d   = hits_q;
    points_d = points_q;
    level_d  = level_q;
    lives_d  = lives_q;
    blink_d  = blink_q;
    if (start_edge) begin
      state_d  = StPlay;
      pos_d    = '0;
      tick_d   = '0;
      period_d = PerW'(MaxPeriod);
      hits_d   = '0;
      points_d = '0;
      level_d  = '0;
      lives_d  = LivesW'(Lives);
      blink_d  = 1'b0;
    end else begin
      unique case (state_q)
        StPlay: begin
          if (btn_edge != '0) begin
            // Hit/miss wins over the step terminal count, so pos never double-advances.
            if (btn_edge == onehot) begin
              points_d = sum[PointsWidth] ? '1 : sum[PointsWidth-1:0];
              tick_d   = '0;
              state_d  = StFlash;
              if (32'(hits_q) + 1 == LevelUpHits) begin
                hits_d = '0;
                if (32'(level_q) < MaxLevel) begin
                  level_d  = level_q + 1'b1;
                  period_d = (32'(period_q) >= MinPeriod + PeriodStep) ?
                             period_q - PerW'(PeriodStep) : PerW'(MinPeriod);
                end
              end else begin
                hits_d = hits_q + 1'b1;
              end
            end else begin
              lives_d = lives_q - 1'b1;
              if (lives_q == LivesW'(1)) begin
                state_d = StOver;
                tick_d  = '0;
                blink_d = 1'b1;
              end
            end
          end else if (32'(tick_q) + 1 == 32'(period_q)) begin
            tick_d = '0;
            pos_d  = step_pos(pos_q, dir);
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StFlash: begin
          if (32'(tick_q) + 1 == FlashCycles) begin
            tick_d  = '0;
            pos_d   = flash_pos;
            state_d = StPlay;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StOver: begin
          if (32'(tick_q) + 1 == MaxPeriod) begin
            tick_d  = '0;
            blink_d = ~blink_q;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pos_q    <= '0;
      tick_q   <= '0;
      period_q <= PerW'(MaxPeriod);
      hits_q   <= '0;
      points_q <= '0;
      level_q  <= '0;
      lives_q  <= LivesW'(Lives);
      blink_q  <= 1'b0;
      button_q <= '1;
      start_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      period_q <= period_d;
      hits_q   <= hits_d;
      points_q <= points_d;
      level_q  <= level_d;
      lives_q  <= lives_d;
      blink_q  <= blink_d;
      button_q <= button;
      start_q  <= start;
    end
  end

  always_comb begin
    led = '0;
    unique case (state_q)
      StPlay:  led = onehot;
      StFlash: led = '1;
      StOver:  led = blink_q ? '1 : '0;
      default: led = '0;
    endcase
  end

  assign points    = points_q;
  assign level     = level_q;
  assign lives     = lives_q;
  assign game_over = (state_q == StOver);

endmodule
